data_memory: RTL and testbench

Data-memory responder at the far end of the core's memory-stage dmem port. Same cycle it returns sized, sign- or zero-extended load data for the presented address. On the clock edge it commits byte-, half- or word-granular stores. It also decodes a small MMIO window: a free-running 64-bit cycle counter and a TOHOST register that raises a sticky simulation halt.

---
 rtl/data_memory_if.sv | 26 ++
 rtl/data_memory.sv | 153 +++++++++++++++
 tb/tb_data_memory.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_if.sv
// data_memory_if: dmem port between the core memory stage (master) and the
// data memory (slave).
//   dmemAddr    byte address
//   dmemWdata   right-aligned store data
//   dmemWen     store request for this cycle
//   dmemSize    RISC-V funct3 access size
//   dmemRdata   combinational load data
//   accessFault combinational fault flag for the current access
interface data_memory_if;
    logic [31:0] dmemAddr;
    logic [31:0] dmemWdata;
    logic        dmemWen;
    logic [2:0]  dmemSize;
    logic [31:0] dmemRdata;
    logic        accessFault;

    modport master (
        output dmemAddr, dmemWdata, dmemWen, dmemSize,
        input  dmemRdata, accessFault
    );

    modport slave (
        input  dmemAddr, dmemWdata, dmemWen, dmemSize,
        output dmemRdata, accessFault
    );
endinterface

// File: rtl/data_memory.sv
// data_memory: zero-latency data memory with a 16-byte MMIO window.
//   clk, rst     clock and synchronous active-high reset
//   bus          dmem slave port (address/size/store in, load data/fault out)
//   halt         sticky, set by a nonzero TOHOST store
//   tohostValue  last value stored to TOHOST
// Loads are combinational; stores, TOHOST and the 64-bit cycle counter
// update on posedge clk. RAM contents are not touched by rst.
module data_memory #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic                clk,
    input  logic                rst,
    data_memory_if.slave        bus,
    output logic                halt,
    output logic [31:0]         tohostValue
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(4 * DEPTH_WORDS);

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    localparam logic [1:0] OFF_TOHOST = 2'd0;
    localparam logic [1:0] OFF_CYC_LO = 2'd1;
    localparam logic [1:0] OFF_CYC_HI = 2'd2;

    logic [3:0][7:0] mem [DEPTH_WORDS];

    logic [31:0] addr;
    logic [2:0]  sz;
    logic [1:0]  off;
    logic [AW-1:0] idx;
    logic        ram_hit, mmio_hit, bad_size, misal, fault;

    logic [63:0] cycle_q, cycle_d;
    logic        halt_q, halt_d;
    logic [31:0] tohost_q, tohost_d;

    assign addr = bus.dmemAddr;
    assign sz   = bus.dmemSize;
    assign off  = addr[3:2];
    assign idx  = addr[2 +: AW];

    // RAM takes priority if a large RAM ever overlaps the MMIO window.
    assign ram_hit  = {1'b0, addr} < RAM_BYTES;
    assign mmio_hit = !ram_hit && (addr[31:4] == MMIO_BASE[31:4]);
    assign bad_size = (sz == 3'b011) || (sz[2] && sz[1]);
    assign misal    = ((sz[1:0] == 2'b01) && addr[0]) ||
                      ((sz == SZ_W) && (addr[1:0] != 2'b00));

    // Stores to the counter fault, so the fault flag depends on dmemWen.
    assign fault = bad_size || misal || !(ram_hit || mmio_hit) ||
                   (mmio_hit && (sz != SZ_W)) ||
                   (mmio_hit && bus.dmemWen &&
                    ((off == OFF_CYC_LO) || (off == OFF_CYC_HI)));

    assign bus.accessFault = fault;

    // ---------------- load path ----------------
    logic [31:0] ram_word, mmio_word, rdata;
    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    always_comb begin
        ram_word = mem[idx];
        rbyte    = ram_word[8*addr[1:0] +: 8];
        rhalf    = addr[1] ? ram_word[31:16] : ram_word[15:0];
        case (off)
            OFF_TOHOST: mmio_word = tohost_q;
            OFF_CYC_LO: mmio_word = cycle_q[31:0];
            OFF_CYC_HI: mmio_word = cycle_q[63:32];
            default:    mmio_word = 32'h0;
        endcase
        rdata = 32'h0;
        if (!fault) begin
            if (mmio_hit) rdata = mmio_word;
            else begin
                case (sz)
                    SZ_B:    rdata = {{24{rbyte[7]}}, rbyte};
                    SZ_H:    rdata = {{16{rhalf[15]}}, rhalf};
                    SZ_BU:   rdata = {24'h0, rbyte};
                    SZ_HU:   rdata = {16'h0, rhalf};
                    default: rdata = ram_word;
                endcase
            end
        end
    end

    assign bus.dmemRdata = rdata;

    // ---------------- store path ----------------
    logic        wr_ok;
    logic [3:0]  be;
    logic [3:0][7:0] wlane;

    assign wr_ok = bus.dmemWen && !fault && !rst;

    always_comb begin
        case (sz[1:0])
            2'b00: begin
                be    = 4'b0001 << addr[1:0];
                wlane = {4{bus.dmemWdata[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wlane = {2{bus.dmemWdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = bus.dmemWdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_ok && ram_hit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][b] <= wlane[b];
            end
        end
    end

    // ---------------- MMIO state ----------------
    always_comb begin
        cycle_d  = cycle_q + 64'd1;
        halt_d   = halt_q;
        tohost_d = tohost_q;
        if (wr_ok && mmio_hit && (off == OFF_TOHOST)) begin
            tohost_d = bus.dmemWdata;
            if (bus.dmemWdata != 32'h0) halt_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_q  <= 64'h0;
            halt_q   <= 1'b0;
            tohost_q <= 32'h0;
        end else begin
            cycle_q  <= cycle_d;
            halt_q   <= halt_d;
            tohost_q <= tohost_d;
        end
    end

    assign halt        = halt_q;
    assign tohostValue = tohost_q;
endmodule

// File: tb/tb_data_memory.sv
`timescale 1ns/1ps
// tb_data_memory: scoreboard bench for data_memory. Expected load data and
// fault flags are queued when an access is driven and popped when the
// combinational response is sampled, 1ns after the driving negedge.
module tb_data_memory;
    localparam logic [2:0] B = 3'b000, H = 3'b001, W = 3'b010;
    localparam logic [2:0] BU = 3'b100, HU = 3'b101;
    localparam logic [31:0] MB = 32'hFFFF_0000;

    typedef struct {
        logic [31:0] a;
        logic [31:0] wd;
        logic        we;
        logic [2:0]  sz;
        logic [31:0] rd;
        logic        chk;
        logic        flt;
    } step_t;

    typedef struct {
        string       name;
        logic [31:0] rd;
        logic        chk;
        logic        flt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        halt;
    logic [31:0] tohostValue;
    int          passed = 0;
    int          total  = 0;
    exp_t        sbq[$];

    data_memory_if bus();

    data_memory #(.DEPTH_WORDS(4096), .MMIO_BASE(MB), .INIT_FILE("")) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .halt(halt),
        .tohostValue(tohostValue)
    );

    always #5 clk = ~clk;

    task automatic drive(input step_t s, input string name);
        @(negedge clk);
        bus.dmemAddr  = s.a;
        bus.dmemWdata = s.wd;
        bus.dmemWen   = s.we;
        bus.dmemSize  = s.sz;
        sbq.push_back('{name, s.rd, s.chk, s.flt});
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        repeat (2) @(negedge clk);
        bus.dmemAddr = MB + 32'h4; bus.dmemWdata = 0; bus.dmemWen = 0; bus.dmemSize = W;
        sbq.push_back('{"rst_cycle_lo", 32'h0, 1'b1, 1'b0});
        #1;
        e = sbq.pop_front();
        total++;
        if (bus.dmemRdata !== e.rd || bus.accessFault !== e.flt)
            $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
        else passed++;
        total++;
        if (halt !== 1'b0 || tohostValue !== 32'h0)
            $display("FAIL rst_state halt=%b tohost=%h want 0/0", halt, tohostValue);
        else passed++;
    endtask

    task automatic test_counter();
        exp_t e;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k == 0) rst = 1'b0;
            bus.dmemAddr = MB + 32'h4; bus.dmemWen = 0; bus.dmemSize = W;
            sbq.push_back('{$sformatf("cnt_%0d", k), 32'(k), 1'b1, 1'b0});
            #1;
            e = sbq.pop_front();
            total++;
            if (bus.dmemRdata !== e.rd || bus.accessFault !== e.flt)
                $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
            else passed++;
        end
        // Preload just below the 32-bit carry; the next edge carries into HI.
        @(negedge clk);
        force dut.cycle_q = 64'h0000_0000_FFFF_FFFF;
        #1;
        release dut.cycle_q;
        begin
            step_t st[$];
            st.push_back('{MB + 32'h4, 32'h0,    1'b0, W, 32'h0, 1'b1, 1'b0});
            st.push_back('{MB + 32'h8, 32'h0,    1'b0, W, 32'h1, 1'b1, 1'b0});
            st.push_back('{MB + 32'h4, 32'h1234, 1'b1, W, 32'h0, 1'b1, 1'b1});
            st.push_back('{MB + 32'h4, 32'h0,    1'b0, W, 32'h3, 1'b1, 1'b0});
            st.push_back('{MB + 32'h8, 32'h0,    1'b0, W, 32'h1, 1'b1, 1'b0});
            foreach (st[i]) begin
                drive(st[i], $sformatf("cnt_wrap_%0d", i));
                e = sbq.pop_front();
                total++;
                if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd))
                    $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
                else passed++;
            end
        end
    endtask

    task automatic test_byte_loads();
        step_t st[$];
        exp_t  e;
        st.push_back('{32'h100, 32'h8081_8283, 1'b1, W,  32'h0,         1'b0, 1'b0});
        st.push_back('{32'h101, 32'h0,         1'b0, B,  32'hFFFF_FF82, 1'b1, 1'b0});
        st.push_back('{32'h101, 32'h0,         1'b0, BU, 32'h0000_0082, 1'b1, 1'b0});
        st.push_back('{32'h102, 32'h0,         1'b0, H,  32'hFFFF_8081, 1'b1, 1'b0});
        st.push_back('{32'h100, 32'h0,         1'b0, HU, 32'h0000_8283, 1'b1, 1'b0});
        st.push_back('{32'h103, 32'h0,         1'b0, BU, 32'h0000_0080, 1'b1, 1'b0});
        st.push_back('{32'h100, 32'h0,         1'b0, W,  32'h8081_8283, 1'b1, 1'b0});
        foreach (st[i]) begin
            drive(st[i], $sformatf("byte_%0d", i));
            e = sbq.pop_front();
            total++;
            if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd))
                $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
            else passed++;
        end
    endtask

    task automatic test_partial_store();
        step_t st[$];
        exp_t  e;
        st.push_back('{32'h200, 32'h1122_3344, 1'b1, W, 32'h0,         1'b0, 1'b0});
        st.push_back('{32'h202, 32'hFFFF_FFAB, 1'b1, B, 32'h0,         1'b0, 1'b0});
        st.push_back('{32'h200, 32'h5555_BEEF, 1'b1, H, 32'h0,         1'b0, 1'b0});
        st.push_back('{32'h200, 32'h0,         1'b0, W, 32'h11AB_BEEF, 1'b1, 1'b0});
        foreach (st[i]) begin
            drive(st[i], $sformatf("partial_%0d", i));
            e = sbq.pop_front();
            total++;
            if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd))
                $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
            else passed++;
        end
    endtask

    task automatic test_faults();
        step_t st[$];
        exp_t  e;
        st.push_back('{32'h203,      32'h0,    1'b0, W,      32'h0,         1'b1, 1'b1});
        st.push_back('{32'h201,      32'hFFFF, 1'b1, H,      32'h0,         1'b1, 1'b1});
        st.push_back('{32'h200,      32'h0,    1'b0, W,      32'h11AB_BEEF, 1'b1, 1'b0});
        st.push_back('{32'h200,      32'h0,    1'b0, 3'b011, 32'h0,         1'b1, 1'b1});
        st.push_back('{32'h200,      32'h0,    1'b0, 3'b110, 32'h0,         1'b1, 1'b1});
        st.push_back('{32'h4000,     32'h0,    1'b0, W,      32'h0,         1'b1, 1'b1});
        st.push_back('{32'h3FFC,     32'h0,    1'b0, W,      32'h0,         1'b0, 1'b0});
        st.push_back('{MB,           32'h5,    1'b1, B,      32'h0,         1'b1, 1'b1});
        st.push_back('{MB + 32'hC,   32'h7,    1'b1, W,      32'h0,         1'b1, 1'b0});
        st.push_back('{MB,           32'h0,    1'b0, W,      32'h0,         1'b1, 1'b0});
        foreach (st[i]) begin
            drive(st[i], $sformatf("fault_%0d", i));
            e = sbq.pop_front();
            total++;
            if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd))
                $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
            else passed++;
        end
        total++;
        if (tohostValue !== 32'h0 || halt !== 1'b0)
            $display("FAIL fault_tohost tohost=%h halt=%b want 0/0", tohostValue, halt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        step_t st[$];
        exp_t  e;
        st.push_back('{32'h300, 32'h0,         1'b1, W, 32'h0,         1'b0, 1'b0});
        st.push_back('{32'h300, 32'hDEAD_BEEF, 1'b1, W, 32'h0,         1'b1, 1'b0});
        st.push_back('{32'h300, 32'h0,         1'b0, W, 32'hDEAD_BEEF, 1'b1, 1'b0});
        foreach (st[i]) begin
            drive(st[i], $sformatf("raw_%0d", i));
            e = sbq.pop_front();
            total++;
            if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd))
                $display("FAIL %s rdata=%h fault=%b want %h/%b", e.name, bus.dmemRdata, bus.accessFault, e.rd, e.flt);
            else passed++;
        end
    endtask

    task automatic test_tohost();
        step_t st[$];
        logic  exp_halt[$];
        logic [31:0] exp_th[$];
        exp_t  e;
        // Each row: halt/tohostValue expected while this row is presented.
        st.push_back('{MB, 32'h0, 1'b1, W, 32'h0, 1'b1, 1'b0}); exp_halt.push_back(0); exp_th.push_back(32'h0);
        st.push_back('{MB, 32'h1, 1'b1, W, 32'h0, 1'b1, 1'b0}); exp_halt.push_back(0); exp_th.push_back(32'h0);
        st.push_back('{MB, 32'h0, 1'b0, W, 32'h1, 1'b1, 1'b0}); exp_halt.push_back(1); exp_th.push_back(32'h1);
        st.push_back('{MB, 32'h0, 1'b1, W, 32'h1, 1'b1, 1'b0}); exp_halt.push_back(1); exp_th.push_back(32'h1);
        st.push_back('{MB, 32'h0, 1'b0, W, 32'h0, 1'b1, 1'b0}); exp_halt.push_back(1); exp_th.push_back(32'h0);
        foreach (st[i]) begin
            drive(st[i], $sformatf("tohost_%0d", i));
            e = sbq.pop_front();
            total++;
            if (bus.accessFault !== e.flt || (e.chk && bus.dmemRdata !== e.rd) ||
                halt !== exp_halt[i] || tohostValue !== exp_th[i])
                $display("FAIL %s rdata=%h fault=%b halt=%b tohost=%h want %h/%b/%b/%h", e.name,
                         bus.dmemRdata, bus.accessFault, halt, tohostValue, e.rd, e.flt, exp_halt[i], exp_th[i]);
            else passed++;
        end
        // Reset mid-run: a store during rst is dropped, RAM survives.
        @(negedge clk);
        rst = 1'b1;
        bus.dmemAddr = MB; bus.dmemWdata = 32'h9; bus.dmemWen = 1'b1; bus.dmemSize = W;
        @(negedge clk);
        rst = 1'b0;
        bus.dmemAddr = 32'h100; bus.dmemWen = 1'b0;
        sbq.push_back('{"rst_ram_kept", 32'h8081_8283, 1'b1, 1'b0});
        #1;
        e = sbq.pop_front();
        total++;
        if (halt !== 1'b0 || tohostValue !== 32'h0 || bus.dmemRdata !== e.rd || bus.accessFault !== e.flt)
            $display("FAIL %s halt=%b tohost=%h rdata=%h want 0/0/%h", e.name, halt, tohostValue, bus.dmemRdata, e.rd);
        else passed++;
    endtask

    initial begin
        bus.dmemAddr = 0; bus.dmemWdata = 0; bus.dmemWen = 0; bus.dmemSize = W;
        test_reset();
        test_counter();
        test_byte_loads();
        test_partial_store();
        test_faults();
        test_back_to_back();
        test_tohost();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
